// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared CPU widths, constants and fetch queue types        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [XLEN-1:0]    PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic int unsigned q_count(input q_state_t s);
        case (s)
            Q_ONE:   q_count = 1;
            Q_FULL:  q_count = 2;
            default: q_count = 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue : two-entry FIFO of {pc, instr}, head always in slot 0  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  fq_entry_t data_i,
    output fq_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    q_state_t  state_q, state_d;
    fq_entry_t slot0_q, slot0_d;
    fq_entry_t slot1_q, slot1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= Q_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload needs no reset: it is only observed while the state says valid.
    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (clear_i) begin
            state_d = Q_EMPTY;
        end else begin
            case (state_q)
                Q_EMPTY: begin
                    if (push_i) begin
                        slot0_d = data_i;
                        state_d = Q_ONE;
                    end
                end
                Q_ONE: begin
                    case ({push_i, pop_i})
                        2'b10: begin
                            slot1_d = data_i;
                            state_d = Q_FULL;
                        end
                        2'b01: state_d = Q_EMPTY;
                        2'b11: slot0_d = data_i;
                        default: ;
                    endcase
                end
                Q_FULL: begin
                    if (pop_i) begin
                        slot0_d = slot1_q;
                        if (push_i) begin
                            slot1_d = data_i;
                        end else begin
                            state_d = Q_ONE;
                        end
                    end
                end
                default: state_d = Q_EMPTY;
            endcase
        end
    end

    always_comb begin
        data_o = slot0_q;
        if (state_q == Q_EMPTY) begin
            data_o.instr = NOP;
        end
    end

    assign empty_o = (state_q == Q_EMPTY);
    assign full_o  = (q_count(state_q) == DEPTH);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : PC generation, redirect and 2-deep fetch queue        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    output logic               if_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_pc_plus4,
    output logic [15:0]        perf_stall
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [15:0]     stall_q, stall_d;
    logic            pop, push, q_full, q_empty;
    fq_entry_t       wr_entry, head;

    // A redirect squashes both the handshake and the fetch of that cycle.
    assign pop  = if_valid && id_ready && !branch_taken;
    assign push = !branch_taken && (!q_full || pop);

    assign wr_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear_i (branch_taken),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .data_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        stall_d = stall_q;
        if (branch_taken) begin
            pc_d = {branch_target[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
        if (if_valid && !id_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            stall_q <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            stall_q <= stall_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = !q_empty;
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + PC_STEP;
    assign perf_stall  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;

    logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_pc4;
    logic        a_valid;
    logic [15:0] a_stall;
    logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc4;
    logic        b_valid;
    logic [15:0] b_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory models: word is a fixed function of its address.
    assign a_rdata = ~a_addr;
    assign b_rdata = b_addr ^ 32'h5A5A_5A5A;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (a_addr),
        .imem_rdata    (a_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (a_valid),
        .id_ready      (id_ready),
        .if_instr      (a_instr),
        .if_pc         (a_pc),
        .if_pc_plus4   (a_pc4),
        .perf_stall    (a_stall)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (b_addr),
        .imem_rdata    (b_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (b_valid),
        .id_ready      (id_ready),
        .if_instr      (b_instr),
        .if_pc         (b_pc),
        .if_pc_plus4   (b_pc4),
        .perf_stall    (b_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b1;

        // Reset state
        step();
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_addr",  a_addr, 32'h0);
        chk("rst_stall", {16'd0, a_stall}, 32'd0);
        chk("rst_addr_wrap", b_addr, 32'hFFFF_FFF8);

        // Streaming with id_ready held high
        rst = 1'b0;
        step();
        chk("s0_valid", {31'd0, a_valid}, 32'd1);
        chk("s0_pc",    a_pc, 32'h0);
        chk("s0_instr", a_instr, 32'hFFFF_FFFF);
        chk("s0_addr",  a_addr, 32'h4);
        chk("w0_pc",    b_pc, 32'hFFFF_FFF8);
        step();
        chk("s1_pc",    a_pc, 32'h4);
        chk("s1_pc4",   a_pc4, 32'h8);
        chk("w1_pc",    b_pc, 32'hFFFF_FFFC);
        chk("w1_pc4",   b_pc4, 32'h0);
        chk("w1_instr", b_instr, 32'hA5A5_A5A6);
        step();
        chk("s2_pc",    a_pc, 32'h8);
        chk("w2_pc",    b_pc, 32'h0);
        step();
        chk("s3_pc",    a_pc, 32'hC);
        chk("s3_instr", a_instr, 32'hFFFF_FFF3);

        // Backpressure fills the queue, then drains in order
        rst = 1'b1;
        step();
        rst      = 1'b0;
        id_ready = 1'b0;
        step();
        chk("bp1_stall", {16'd0, a_stall}, 32'd0);
        step();
        step();
        step();
        chk("bp_addr",  a_addr, 32'h8);
        chk("bp_stall", {16'd0, a_stall}, 32'd3);
        chk("bp_head",  a_pc, 32'h0);
        id_ready = 1'b1;
        step();
        chk("dr_head1", a_pc, 32'h4);
        chk("dr_stall", {16'd0, a_stall}, 32'd3);
        step();
        chk("dr_head2", a_pc, 32'h8);
        step();
        chk("dr_head3", a_pc, 32'hC);
        chk("dr_full_addr", a_addr, 32'h14);

        // Redirect while full with the decoder ready
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        chk("br_valid", {31'd0, a_valid}, 32'd0);
        chk("br_addr",  a_addr, 32'h100);
        step();
        chk("br_valid2", {31'd0, a_valid}, 32'd1);
        chk("br_pc",     a_pc, 32'h100);
        chk("br_instr",  a_instr, 32'hFFFF_FEFF);

        // Long stall: perf counter saturates
        id_ready = 1'b0;
        for (int i = 0; i < 65531; i++) step();
        chk("sat_pre", {16'd0, a_stall}, 32'h0000_FFFE);
        step();
        chk("sat_hit", {16'd0, a_stall}, 32'h0000_FFFF);
        for (int i = 0; i < 4468; i++) step();
        chk("sat_hold", {16'd0, a_stall}, 32'h0000_FFFF);
        chk("sat_pc",   a_pc, 32'h100);

        // Reset mid-stall overrides a concurrent redirect
        rst           = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        chk("mr_stall", {16'd0, a_stall}, 32'd0);
        chk("mr_valid", {31'd0, a_valid}, 32'd0);
        chk("mr_addr",  a_addr, 32'h0);
        chk("mr_addr_wrap", b_addr, 32'hFFFF_FFF8);
        rst          = 1'b0;
        branch_taken = 1'b0;
        step();
        chk("mr_pc", a_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 2, fetch queue depth in entries; only value 2 is supported.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_addr  out  32  instruction memory address, equal to current PC (combinational from PC register).
REQ-007 imem_rdata  in  32  instruction word at imem_addr, combinational memory, same cycle.
REQ-008 branch_taken  in  1  redirect request from execute stage.
REQ-009 branch_target  in  32  redirect PC, sampled when branch_taken=1.
REQ-010 if_valid  out  1  queue head holds a valid instruction.
REQ-011 id_ready  in  1  decode stage accepts head this cycle.
REQ-012 if_instr  out  32  head instruction word.
REQ-013 if_pc  out  32  PC of head instruction.
REQ-014 if_pc_plus4  out  32  if_pc+4, modulo 2^32.
REQ-015 perf_stall  out  16  cycles with if_valid=1 and id_ready=0, saturating.

Function
REQ-016 Handshake: pop occurs iff if_valid=1, id_ready=1 and branch_taken=0.
REQ-017 Push occurs iff branch_taken=0 and (queue not full or pop this cycle); a push stores {PC, imem_rdata} and sets PC<=PC+4.
REQ-018 PC increment SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 Fetch latency SHALL be 1 cycle: a word pushed in cycle N appears on if_instr in cycle N+1 if the queue was empty.
REQ-020 Queue state machine: EMPTY, ONE, FULL; push-only advances one state, pop-only retreats one state, push+pop holds state, neither holds state.
REQ-021 FULL with no pop: no push, PC holds, imem_addr stable.
REQ-022 Queue order SHALL be FIFO; if_instr/if_pc/if_pc_plus4 reflect the oldest entry, and are don't-care when if_valid=0.
REQ-023 Redirect (branch_taken=1) has priority over everything: queue cleared to EMPTY, PC<=branch_target with bits [1:0] forced to 00, no push, no pop in that cycle.
REQ-024 A handshake coincident with branch_taken SHALL be discarded; the decoder sees no accepted instruction.
REQ-025 First instruction after redirect SHALL be fetched in cycle N+1 and valid in cycle N+2.
REQ-026 perf_stall increments each cycle with if_valid=1, id_ready=0; holds at 16'hFFFF.
REQ-027 if_valid SHALL be driven from queue state only (registered), never from id_ready.

Reset
REQ-028 On rst=1 at posedge: PC=RESET_PC, queue=EMPTY, if_valid=0, perf_stall=0; rst overrides branch_taken and any handshake.
REQ-029 First cycle after rst deasserts SHALL fetch RESET_PC; if_valid=1 one cycle later.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries with no partial pop.

Structure
REQ-031 Shared package cpu_pkg SHALL hold XLEN=32, INSTR_W=32, PC_STEP=4, the NOP encoding 32'h0000_0000, and the queue state enum.
REQ-032 Queue storage and state machine SHALL be a sub-module fetch_queue (push, pop, clear, data in/out, full, empty); PC register, redirect logic and perf counter live in fetch_stage.

Verification
REQ-033 Reset, then id_ready=1 constant for 5 cycles -> if_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles starting 1 cycle after reset release.
REQ-034 id_ready=0 for 4 cycles after reset -> queue FULL after 2 pushes; PC holds 0x8; perf_stall=3; on id_ready=1, heads 0x0, 0x4, 0x8 in order, none lost or duplicated.
REQ-035 branch_taken=1 with branch_target=0x0000_0103 while FULL and id_ready=1 -> if_valid=0 next cycle; no pop; imem_addr=0x100; if_pc=0x100 one cycle later.
REQ-036 RESET_PC=0xFFFF_FFF8, id_ready=1 -> if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, with if_pc_plus4=0x0 at 0xFFFF_FFFC.
REQ-037 id_ready=0 for 70000 cycles -> perf_stall saturates at 0xFFFF; rst mid-stall -> perf_stall=0, if_valid=0, imem_addr=RESET_PC next cycle.
